// File: rtl/v_upd_ingress.sv
// v_pkg / v_upd_ingress
//
// Purpose: ingress buffer for list-update commands. Accepted commands are held in
// a circular FIFO of DEPTH entries and issued in order on the update bus as soon as
// the downstream list engine is not busy. The engine has no backpressure, so every
// cycle in which o_upd_vld is high pops the head entry.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   i_in_vld / o_in_rdy      upstream command handshake
//   i_in_prod_id, i_in_cmd,
//   i_in_key, i_in_size      command fields
//   i_flush                  discard every buffered entry at the next edge
//   i_busy                   downstream engine initialising; hold entries
//   o_upd_vld, o_upd_*       update bus (head entry; fields are 0 when empty)
//   o_cnt_r                  registered occupancy 0..DEPTH
//   o_ovf_r                  sticky: a push was attempted while full

package v_pkg;
  typedef logic [7:0]  id_t;
  typedef logic [1:0]  cmd_t;
  typedef logic [15:0] key_t;
  typedef logic [11:0] size_t;

  typedef struct packed {
    id_t   prod_id;
    cmd_t  cmd;
    key_t  key;
    size_t size;
  } entry_t;
endpackage

module v_upd_ingress #(
  parameter int DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_in_vld,
  output logic                              o_in_rdy,
  input  logic [$bits(v_pkg::id_t)-1:0]     i_in_prod_id,
  input  logic [$bits(v_pkg::cmd_t)-1:0]    i_in_cmd,
  input  logic [$bits(v_pkg::key_t)-1:0]    i_in_key,
  input  logic [$bits(v_pkg::size_t)-1:0]   i_in_size,
  input  logic                              i_flush,
  input  logic                              i_busy,
  output logic                              o_upd_vld,
  output logic [$bits(v_pkg::id_t)-1:0]     o_upd_prod_id,
  output logic [$bits(v_pkg::cmd_t)-1:0]    o_upd_cmd,
  output logic [$bits(v_pkg::key_t)-1:0]    o_upd_key,
  output logic [$bits(v_pkg::size_t)-1:0]   o_upd_size,
  output logic [$clog2(DEPTH):0]            o_cnt_r,
  output logic                              o_ovf_r
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  // Pointer advance with explicit wrap at DEPTH-1.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    logic [PW-1:0] n;
    if (p == PTR_LAST) begin
      n = PTR_ZERO;
    end else begin
      n = p + PW'(1);
    end
    return n;
  endfunction

  v_pkg::entry_t  mem_r [DEPTH];
  logic [PW-1:0]  wr_ptr_r;
  logic [PW-1:0]  rd_ptr_r;

  logic           full_s;
  logic           empty_s;
  logic           push_s;
  logic           pop_s;
  logic           ovf_set_s;
  v_pkg::entry_t  wr_ent_s;
  v_pkg::entry_t  head_s;

  // Handshake, pop and overflow decode. Ready deliberately ignores the pop in the
  // same cycle: a full FIFO never admits a push, even while it is draining.
  always_comb begin
    full_s    = (o_cnt_r == CNT_FULL);
    empty_s   = (o_cnt_r == CNT_ZERO);
    o_in_rdy  = !full_s && !i_flush;
    push_s    = i_in_vld && o_in_rdy;
    o_upd_vld = !empty_s && !i_busy && !i_flush;
    pop_s     = o_upd_vld;
    ovf_set_s = i_in_vld && full_s && !i_flush;
  end

  // Pack the incoming command into one storage word.
  always_comb begin
    wr_ent_s         = '{default: '0};
    wr_ent_s.prod_id = i_in_prod_id;
    wr_ent_s.cmd     = i_in_cmd;
    wr_ent_s.key     = i_in_key;
    wr_ent_s.size    = i_in_size;
  end

  // Head entry; forced to zero when empty so stale storage never shows on the bus.
  always_comb begin
    head_s = '{default: '0};
    if (!empty_s) begin
      head_s = mem_r[rd_ptr_r];
    end else begin
      head_s = '{default: '0};
    end
    o_upd_prod_id = head_s.prod_id;
    o_upd_cmd     = head_s.cmd;
    o_upd_key     = head_s.key;
    o_upd_size    = head_s.size;
  end

  // Entry storage: written on an admitted push only; contents need no reset.
  always_ff @(posedge clk) begin
    if (push_s && rst) begin
      mem_r[wr_ptr_r] <= wr_ent_s;
    end
  end

  // Pointers and occupancy; flush wins over any push/pop (neither is issued then).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      o_cnt_r  <= CNT_ZERO;
    end else if (i_flush) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      o_cnt_r  <= CNT_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   o_cnt_r <= o_cnt_r + CW'(1);
        2'b01:   o_cnt_r <= o_cnt_r - CW'(1);
        default: o_cnt_r <= o_cnt_r;
      endcase
    end
  end

  // Sticky overflow flag; only reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_ovf_r <= 1'b0;
    end else if (ovf_set_s) begin
      o_ovf_r <= 1'b1;
    end else begin
      o_ovf_r <= o_ovf_r;
    end
  end

endmodule

// File: tb/tb_v_upd_ingress.sv
// Scoreboard bench for v_upd_ingress (DEPTH=4). Stimulus pushes every command it
// expects to be accepted into a queue; a negedge monitor pops and compares each
// entry the DUT presents on the update bus.
module tb_v_upd_ingress;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        i_in_vld;
  logic        o_in_rdy;
  logic [7:0]  i_in_prod_id;
  logic [1:0]  i_in_cmd;
  logic [15:0] i_in_key;
  logic [11:0] i_in_size;
  logic        i_flush;
  logic        i_busy;
  logic        o_upd_vld;
  logic [7:0]  o_upd_prod_id;
  logic [1:0]  o_upd_cmd;
  logic [15:0] o_upd_key;
  logic [11:0] o_upd_size;
  logic [2:0]  o_cnt_r;
  logic        o_ovf_r;

  v_upd_ingress #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .i_in_vld(i_in_vld), .o_in_rdy(o_in_rdy),
    .i_in_prod_id(i_in_prod_id), .i_in_cmd(i_in_cmd),
    .i_in_key(i_in_key), .i_in_size(i_in_size),
    .i_flush(i_flush), .i_busy(i_busy),
    .o_upd_vld(o_upd_vld), .o_upd_prod_id(o_upd_prod_id),
    .o_upd_cmd(o_upd_cmd), .o_upd_key(o_upd_key), .o_upd_size(o_upd_size),
    .o_cnt_r(o_cnt_r), .o_ovf_r(o_ovf_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int popped = 0;
  int m_cnt  = 0;
  logic m_ovf = 1'b0;
  v_pkg::entry_t sb[$];
  v_pkg::entry_t mon_exp;
  v_pkg::entry_t mon_act;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic v_pkg::entry_t mk(input logic [7:0] id);
    v_pkg::entry_t e;
    e.prod_id = id;
    e.cmd     = id[1:0];
    e.key     = {id, ~id};
    e.size    = {4'h5, id};
    return e;
  endfunction

  // Monitor: every presented update must be the oldest outstanding accepted command.
  always @(negedge clk) begin
    if (rst && o_upd_vld) begin
      checks++;
      mon_act = '{prod_id: o_upd_prod_id, cmd: o_upd_cmd, key: o_upd_key, size: o_upd_size};
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got id %0h, expected no output", o_upd_prod_id);
      end else begin
        mon_exp = sb.pop_front();
        popped++;
        if (mon_act !== mon_exp) begin
          errors++;
          $display("FAIL sb_data: got %0h, expected %0h", mon_act, mon_exp);
        end
      end
    end
  end

  // One cycle: drive at posedge+1, check at negedge, advance reference state.
  task automatic cyc(input logic vld, input v_pkg::entry_t e, input logic busy, input logic flush);
    logic exp_rdy;
    logic exp_vld;
    i_in_vld = vld;
    i_in_prod_id = e.prod_id;
    i_in_cmd = e.cmd;
    i_in_key = e.key;
    i_in_size = e.size;
    i_busy = busy;
    i_flush = flush;
    @(negedge clk);
    exp_rdy = (m_cnt != DEPTH) && !flush;
    exp_vld = (m_cnt != 0) && !busy && !flush;
    chk("in_rdy", 32'(o_in_rdy), 32'(exp_rdy));
    chk("upd_vld", 32'(o_upd_vld), 32'(exp_vld));
    chk("cnt", 32'(o_cnt_r), 32'(m_cnt));
    chk("ovf", 32'(o_ovf_r), 32'(m_ovf));
    if (m_cnt == 0) begin
      chk("empty_fields", 32'({o_upd_prod_id, o_upd_cmd} | {o_upd_key, o_upd_size}), 32'd0);
    end
    if (vld && exp_rdy) sb.push_back(e);
    if (flush) sb.delete();
    if (vld && (m_cnt == DEPTH) && !flush) m_ovf = 1'b1;
    if (flush) m_cnt = 0;
    else m_cnt = m_cnt + int'(vld && exp_rdy) - int'(exp_vld);
    @(posedge clk);
    #1;
  endtask

  int p0;
  v_pkg::entry_t re;
  logic rbusy;

  initial begin
    rst = 1'b0;
    i_in_vld = 1'b0; i_in_prod_id = 8'd0; i_in_cmd = 2'd0; i_in_key = 16'd0;
    i_in_size = 12'd0; i_flush = 1'b0; i_busy = 1'b1;
    #2;
    chk("rst_cnt", 32'(o_cnt_r), 32'd0);
    chk("rst_ovf", 32'(o_ovf_r), 32'd0);
    chk("rst_vld", 32'(o_upd_vld), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rel_rdy", 32'(o_in_rdy), 32'd1);
    chk("rel_vld", 32'(o_upd_vld), 32'd0);

    // Busy: buffer 1,2,3, then drain in order on 3 consecutive cycles.
    for (int i = 1; i <= 3; i++) cyc(1'b1, mk(8'(i)), 1'b1, 1'b0);
    chk("busy3_cnt", 32'(o_cnt_r), 32'd3);
    cyc(1'b0, mk(8'd0), 1'b1, 1'b0);
    p0 = popped;
    for (int i = 0; i < 3; i++) cyc(1'b0, mk(8'd0), 1'b0, 1'b0);
    chk("busy3_popped", 32'(popped - p0), 32'd3);
    chk("busy3_cnt0", 32'(o_cnt_r), 32'd0);

    // Five back-to-back pushes while busy: fifth refused, overflow sticky.
    for (int i = 0; i < 5; i++) cyc(1'b1, mk(8'(10 + i)), 1'b1, 1'b0);
    chk("full_cnt", 32'(o_cnt_r), 32'd4);
    chk("full_ovf", 32'(o_ovf_r), 32'd1);
    // Full while draining: push still refused in the popping cycle.
    cyc(1'b1, mk(8'd15), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, mk(8'd0), 1'b0, 1'b0);
    chk("full_drained", 32'(o_cnt_r), 32'd0);

    // Streaming: one push per cycle, one-cycle latency, pointers wrap.
    p0 = popped;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, mk(8'(20 + i)), 1'b0, 1'b0);
      chk("stream_cnt", 32'(o_cnt_r), 32'd1);
    end
    cyc(1'b0, mk(8'd0), 1'b0, 1'b0);
    chk("stream_popped", 32'(popped - p0), 32'd20);
    chk("stream_cnt0", 32'(o_cnt_r), 32'd0);

    // Flush with a simultaneous push at cnt=3.
    for (int i = 0; i < 3; i++) cyc(1'b1, mk(8'(50 + i)), 1'b1, 1'b0);
    p0 = popped;
    cyc(1'b1, mk(8'd53), 1'b0, 1'b1);
    chk("flush_cnt0", 32'(o_cnt_r), 32'd0);
    cyc(1'b1, mk(8'd54), 1'b0, 1'b0);
    cyc(1'b0, mk(8'd0), 1'b0, 1'b0);
    chk("flush_popped", 32'(popped - p0), 32'd1);

    // Reset mid-cycle with two entries pending and the engine ready.
    for (int i = 0; i < 2; i++) cyc(1'b1, mk(8'(60 + i)), 1'b1, 1'b0);
    i_in_vld = 1'b0; i_busy = 1'b0;
    #1;
    chk("pre_rst_vld", 32'(o_upd_vld), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_vld", 32'(o_upd_vld), 32'd0);
    chk("mid_rst_cnt", 32'(o_cnt_r), 32'd0);
    chk("mid_rst_ovf", 32'(o_ovf_r), 32'd0);
    sb.delete(); m_cnt = 0; m_ovf = 1'b0;
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_rdy", 32'(o_in_rdy), 32'd1);

    // Random traffic with i_busy toggling.
    rbusy = 1'b0;
    for (int i = 0; i < 300; i++) begin
      re.prod_id = 8'($urandom); re.cmd = 2'($urandom);
      re.key = 16'($urandom); re.size = 12'($urandom);
      if ($urandom_range(0, 3) == 0) rbusy = ~rbusy;
      cyc(1'($urandom_range(0, 1)), re, rbusy, 1'b0);
    end
    for (int i = 0; i < DEPTH + 1; i++) cyc(1'b0, mk(8'd0), 1'b0, 1'b0);
    chk("rand_sb_empty", 32'(sb.size()), 32'd0);
    chk("rand_cnt0", 32'(o_cnt_r), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
